// File: rtl/rollo_encrypt_seq.sv
// ROLLO-I/II encapsulation sequencer: start/done handshakes to the engines, then ct memory readout as OUT_W-bit beats.
// Optional per-phase watchdog is enabled by defining ROLLO_SEQ_WATCHDOG_EN.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   S_IDLE   | waiting for start
//   S_EGEN   | support (E) generation running
//   S_CGEN   | e1/e2/c generation running
//   S_MUL    | GF(2^m)[z] multiply running
//   S_HASH   | SHA3 running (KEM mode only)
//   S_RD     | ct memory read issued for current word
//   S_LOAD   | read data captured into the shift buffer
//   S_STREAM | beats of the current word presented on the stream port
//   S_DONE   | one-cycle completion
module rollo_encrypt_seq #(
    parameter int N      = 47,
    parameter int M      = 79,
    parameter int DIGIT  = 4,
    parameter int OUT_W  = 32,
`ifdef ROLLO_SEQ_WATCHDOG_EN
    parameter int WD_MAX = 4095,
`endif
    localparam int W     = M * DIGIT,
    localparam int DEPTH = (N + DIGIT - 1) / DIGIT,
    localparam int BEATS = (W + OUT_W - 1) / OUT_W,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    output logic             egen_start,
    input  logic             egen_done,
    output logic             cgen_start,
    input  logic             cgen_done,
    output logic             mul_start,
    input  logic             mul_done,
    output logic             hash_start,
    input  logic             hash_done,
    output logic [AW-1:0]    ct_addr,
    output logic             ct_en,
    input  logic [W-1:0]     ct_dout,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int BUF_W = BEATS * OUT_W;
    localparam int BCW   = $clog2(BEATS + 1);
    localparam int WCW   = $clog2(DEPTH + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_EGEN, S_CGEN, S_MUL, S_HASH, S_RD, S_LOAD, S_STREAM, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               first_q;
    logic               mode_q;
    logic [BUF_W-1:0]   buf_q;
    logic [BCW-1:0]     beat_q;
    logic [WCW-1:0]     word_q;
    logic               beat_end;
    logic               word_end;

    assign beat_end = (beat_q == BCW'(BEATS - 1));
    assign word_end = (word_q == WCW'(DEPTH - 1));

`ifdef ROLLO_SEQ_WATCHDOG_EN
    localparam int WDW = $clog2(WD_MAX + 1);
    logic [WDW-1:0] wd_q;
    logic           in_phase;
    logic           timeout;
    logic           err_q;

    assign in_phase = (state_q == S_EGEN) || (state_q == S_CGEN) ||
                      (state_q == S_MUL)  || (state_q == S_HASH);
`endif

    always_comb begin
        state_d    = state_q;
        egen_start = 1'b0;
        cgen_start = 1'b0;
        mul_start  = 1'b0;
        hash_start = 1'b0;
        ct_en      = 1'b0;
        ct_addr    = '0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_data   = '0;
        done       = 1'b0;
        // A done in the same cycle as its start is never taken (first_q gate).
        case (state_q)
            S_IDLE:   if (start) state_d = S_EGEN;
            S_EGEN: begin
                egen_start = first_q;
                if (!first_q && egen_done) state_d = S_CGEN;
            end
            S_CGEN: begin
                cgen_start = first_q;
                if (!first_q && cgen_done) state_d = S_MUL;
            end
            S_MUL: begin
                mul_start = first_q;
                if (!first_q && mul_done) state_d = mode_q ? S_RD : S_HASH;
            end
            S_HASH: begin
                hash_start = first_q;
                if (!first_q && hash_done) state_d = S_RD;
            end
            S_RD: begin
                ct_en   = 1'b1;
                ct_addr = word_q[AW-1:0];
                state_d = S_LOAD;
            end
            S_LOAD:   state_d = S_STREAM;
            S_STREAM: begin
                out_valid = 1'b1;
                out_data  = buf_q[OUT_W-1:0];
                out_last  = beat_end && word_end;
                if (out_ready && beat_end) state_d = word_end ? S_DONE : S_RD;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
`ifdef ROLLO_SEQ_WATCHDOG_EN
        timeout = in_phase && (wd_q == '0) && (state_d == state_q);
        if (timeout) begin
            state_d = S_IDLE;
            done    = 1'b1;
        end
`endif
    end

    assign busy = (state_q != S_IDLE) && (state_q != S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            first_q <= 1'b0;
            mode_q  <= 1'b0;
            buf_q   <= '0;
            beat_q  <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            first_q <= (state_d != state_q);
            if (state_q == S_IDLE && start) mode_q <= mode;
            case (state_q)
                S_LOAD: begin
                    buf_q  <= BUF_W'(ct_dout);
                    beat_q <= '0;
                end
                S_STREAM: if (out_ready) begin
                    buf_q  <= buf_q >> OUT_W;
                    beat_q <= beat_q + 1'b1;
                    if (beat_end) word_q <= word_q + 1'b1;
                end
                S_DONE: begin
                    beat_q <= '0;
                    word_q <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef ROLLO_SEQ_WATCHDOG_EN
    // Down-counter reloaded on every state entry; terminal count 0 is cycle WD_MAX of a phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_d != state_q) wd_q <= WDW'(WD_MAX - 1);
            else if (wd_q != '0)    wd_q <= wd_q - 1'b1;
            if (state_q == S_IDLE && start) err_q <= 1'b0;
            else if (timeout)               err_q <= 1'b1;
        end
    end

    assign err = err_q | timeout;
`else
    assign err = 1'b0;
`endif

endmodule
